// File: rtl/cfg_chain_sequencer_if.sv
// Bitstream beat stream into the configuration sequencer: data/valid from the
// source, ready back from the sequencer.
interface cfg_chain_sequencer_if #(
  parameter int NUM_CHAINS = 4
);
  logic [NUM_CHAINS-1:0] bs_data;
  logic                  bs_valid;
  logic                  bs_ready;

  modport master (output bs_data, output bs_valid, input bs_ready);
  modport slave  (input bs_data, input bs_valid, output bs_ready);
endinterface

// File: rtl/cfg_chain_sequencer.sv
// Fabric configuration sequencer: pReset pulse, then streams CHAIN_LEN beats into
// NUM_CHAINS parallel config-flop chains. CFG_SEQ_TAIL_CHECK_EN builds the tail check.
module cfg_chain_lane (
  input  logic prog_clk,
  input  logic pReset_n,
  input  logic clr,
  input  logic load,
  input  logic d,
  input  logic chk,
  input  logic tail,
  input  logic err_clr,
  output logic head,
  output logic err
);
  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n)  head <= 1'b0;
    else if (clr)   head <= 1'b0;
    else if (load)  head <= d;

`ifdef CFG_SEQ_TAIL_CHECK_EN
  // Chains were cleared by pReset, so anything but 0 falling off the tail is a fault.
  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n)           err <= 1'b0;
    else if (clr || err_clr) err <= 1'b0;
    else if (chk && tail)    err <= 1'b1;
`else
  logic unused_lane;
  assign unused_lane = chk ^ tail ^ err_clr;
  assign err = 1'b0;
`endif
endmodule

module cfg_chain_sequencer #(
  parameter int NUM_CHAINS    = 4,
  parameter int CHAIN_LEN     = 1024,
  parameter int PRESET_CYCLES = 8
)(
  input  logic                  prog_clk,
  input  logic                  pReset_n,
  input  logic                  start,
  input  logic                  abort,
  cfg_chain_sequencer_if.slave  bs,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  shift_en,
  output logic                  config_enable,
  output logic                  pReset_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(PRESET_CYCLES + 1);
  localparam logic [CW-1:0] LEN   = CW'(CHAIN_LEN);
  localparam logic [PW-1:0] PLAST = PW'(PRESET_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PRESET, SHIFT, FINISH, DONE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         count;
  logic [PW-1:0]         pcnt;
  logic                  accept, last_beat, launch;
  logic [NUM_CHAINS-1:0] lane_err;

  assign bs.bs_ready = (state == SHIFT) && (count < LEN);
  assign accept      = bs.bs_ready && bs.bs_valid;
  assign last_beat   = accept && (count == LEN - 1'b1);
  assign launch      = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n) state <= IDLE;
    else           state <= state_nxt;

  always_comb begin
    state_nxt     = state;
    pReset_out    = 1'b0;
    config_enable = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = PRESET;
      PRESET: begin
        pReset_out    = 1'b1;
        config_enable = 1'b1;
        busy          = 1'b1;
        if (pcnt == PLAST) state_nxt = SHIFT;
      end
      SHIFT: begin
        config_enable = 1'b1;
        busy          = 1'b1;
        if (last_beat) state_nxt = FINISH;
      end
      // Lets the last shift_en pulse reach the fabric with config_enable still up.
      FINISH: begin
        config_enable = 1'b1;
        busy          = 1'b1;
        state_nxt     = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = PRESET;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n) begin
      pcnt     <= '0;
      count    <= '0;
      shift_en <= 1'b0;
    end else if (abort) begin
      pcnt     <= '0;
      count    <= '0;
      shift_en <= 1'b0;
    end else begin
      shift_en <= accept;
      if (launch)                                pcnt <= '0;
      else if (state == PRESET && pcnt != PLAST) pcnt <= pcnt + 1'b1;
      if (state == PRESET) count <= '0;
      else if (accept)     count <= count + 1'b1;
    end

  for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_lane
    cfg_chain_lane u_lane (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .clr      (abort),
      .load     (accept),
      .d        (bs.bs_data[g]),
      .chk      (shift_en),
      .tail     (ccff_tail[g]),
      .err_clr  (launch),
      .head     (ccff_head[g]),
      .err      (lane_err[g])
    );
  end

  assign error = |lane_err;
endmodule
